// File: rtl/lepton_vospi_emulator.sv
// rtl/lepton_vospi_emulator.sv - VoSPI slave emulating a Lepton packet stream
// Serialises discard/video packets while precomputing the next packet's CRC.
module lepton_vospi_emulator #(
    parameter int PKTS_PER_SEG   = 60,
    parameter int PIX_PER_PKT    = 80,
    parameter int SEGS_PER_FRAME = 4,
    parameter int DISCARD_PKTS   = 2,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        spi_clk,
    input  logic        spi_cs,
    output logic        spi_miso,
    output logic        ready,
    output logic        pkt_done,
    output logic        cs_abort,
    output logic [15:0] pkt_id,
    output logic [2:0]  seg_num,
    output logic [3:0]  frame_count
);
    localparam int PKTS_TOTAL = DISCARD_PKTS + PKTS_PER_SEG;
    localparam int IDX_W      = $clog2(PKTS_TOTAL);
    localparam int WRD_W      = $clog2(PIX_PER_PKT + 2);
    localparam logic [IDX_W-1:0] DISC_L    = IDX_W'(DISCARD_PKTS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKTS_TOTAL - 1);
    localparam logic [IDX_W-1:0] TAG_PKT   = IDX_W'(20);
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(PIX_PER_PKT + 1);
    localparam logic [2:0]       LAST_SEG  = 3'(SEGS_PER_FRAME);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int b = 15; b >= 0; b--) begin
            if (c[15] ^ data[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // for_crc selects the CRC view of a word: ID nibble and CRC field forced to zero.
    function automatic logic [15:0] pkt_word(
        input logic [IDX_W-1:0] idx,
        input logic [2:0]       seg,
        input logic             frame_lsb,
        input logic [15:0]      crc,
        input logic [WRD_W-1:0] w,
        input logic             for_crc
    );
        logic [IDX_W-1:0] n;
        logic [2:0]       seg_m1;
        logic [WRD_W-1:0] pix;
        logic [15:0]      word;
        n      = idx - DISC_L;
        seg_m1 = seg - 3'd1;
        pix    = w - WRD_W'(2);
        word   = 16'h0000;
        if (idx < DISC_L) begin
            if (w == WRD_W'(0))      word = 16'h0FFF;
            else if (w == WRD_W'(1)) word = 16'hFFFF;
        end else if (w == WRD_W'(0)) begin
            word = {4'h0, 12'(n)};
            if (!for_crc && n == TAG_PKT) word[15:12] = {1'b0, seg};
        end else if (w == WRD_W'(1)) begin
            word = for_crc ? 16'h0000 : crc;
        end else begin
            word = {frame_lsb, seg_m1[1:0], 6'(n), 7'(pix)};
        end
        return word;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    state_t                 state_q, state_d;
    logic [3:0]             bit_q, bit_d;
    logic [WRD_W-1:0]       word_q, word_d;
    logic [IDX_W-1:0]       cur_idx_q, cur_idx_d, nxt_idx;
    logic [2:0]             cur_seg_q, cur_seg_d, nxt_seg;
    logic [3:0]             cur_frame_q, cur_frame_d, nxt_frame;
    logic [15:0]            cur_crc_q, cur_crc_d, nxt_crc_q, nxt_crc_d;
    logic                   eng_busy_q, eng_busy_d;
    logic [WRD_W-1:0]       eng_cnt_q, eng_cnt_d;
    logic [15:0]            eng_crc_q, eng_crc_d;
    logic                   ready_q, ready_d, miso_q, miso_d;
    logic                   pkt_done_q, pkt_done_d, cs_abort_q, cs_abort_d;
    logic                   cs_active, sck_rise;
    logic [15:0]            tx_word;

    always_comb begin
        nxt_idx   = cur_idx_q + IDX_W'(1);
        nxt_seg   = cur_seg_q;
        nxt_frame = cur_frame_q;
        if (cur_idx_q == LAST_IDX) begin
            nxt_idx = '0;
            if (cur_seg_q == LAST_SEG) begin
                nxt_seg   = 3'd1;
                nxt_frame = cur_frame_q + 4'd1;
            end else begin
                nxt_seg = cur_seg_q + 3'd1;
            end
        end
    end

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
        cs_active   = ~cs_sync_q[SYNC_STAGES-1] & enable;
        sck_rise    = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
        state_d     = state_q;
        bit_d       = bit_q;
        word_d      = word_q;
        cur_idx_d   = cur_idx_q;
        cur_seg_d   = cur_seg_q;
        cur_frame_d = cur_frame_q;
        cur_crc_d   = cur_crc_q;
        nxt_crc_d   = nxt_crc_q;
        eng_busy_d  = eng_busy_q;
        eng_cnt_d   = eng_cnt_q;
        eng_crc_d   = eng_crc_q;
        ready_d     = ready_q;
        pkt_done_d  = 1'b0;
        cs_abort_d  = 1'b0;

        // CRC of the packet after the current one, one word per clock.
        if (eng_busy_q) begin
            eng_crc_d = crc16_word(eng_crc_q,
                pkt_word(nxt_idx, nxt_seg, nxt_frame[0], 16'h0000, eng_cnt_q, 1'b1));
            eng_cnt_d = eng_cnt_q + WRD_W'(1);
            if (eng_cnt_q == LAST_WORD) begin
                eng_busy_d = 1'b0;
                ready_d    = 1'b1;
                nxt_crc_d  = eng_crc_d;
            end
        end

        if (state_q == S_IDLE) begin
            if (cs_active) state_d = S_SHIFT;
        end else if (!cs_active) begin
            state_d = S_IDLE;
            if (bit_q != 4'd0 || word_q != '0) cs_abort_d = 1'b1;
            bit_d  = 4'd0;
            word_d = '0;
        end else if (sck_rise) begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
                if (word_q == LAST_WORD) begin
                    word_d      = '0;
                    pkt_done_d  = 1'b1;
                    cur_idx_d   = nxt_idx;
                    cur_seg_d   = nxt_seg;
                    cur_frame_d = nxt_frame;
                    cur_crc_d   = nxt_crc_q;
                    eng_busy_d  = 1'b1;
                    eng_cnt_d   = '0;
                    eng_crc_d   = 16'h0000;
                    ready_d     = 1'b0;
                end else begin
                    word_d = word_q + WRD_W'(1);
                end
            end
        end

        tx_word = pkt_word(cur_idx_d, cur_seg_d, cur_frame_d[0], cur_crc_d, word_d, 1'b0);
        miso_d  = cs_active ? tx_word[4'd15 - bit_d] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '1;
            cs_sync_q   <= '1;
            sck_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_q       <= 4'd0;
            word_q      <= '0;
            cur_idx_q   <= '0;
            cur_seg_q   <= 3'd1;
            cur_frame_q <= 4'd0;
            cur_crc_q   <= 16'h0000;
            nxt_crc_q   <= 16'h0000;
            eng_busy_q  <= 1'b1;
            eng_cnt_q   <= '0;
            eng_crc_q   <= 16'h0000;
            ready_q     <= 1'b0;
            miso_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            cs_abort_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            cur_idx_q   <= cur_idx_d;
            cur_seg_q   <= cur_seg_d;
            cur_frame_q <= cur_frame_d;
            cur_crc_q   <= cur_crc_d;
            nxt_crc_q   <= nxt_crc_d;
            eng_busy_q  <= eng_busy_d;
            eng_cnt_q   <= eng_cnt_d;
            eng_crc_q   <= eng_crc_d;
            ready_q     <= ready_d;
            miso_q      <= miso_d;
            pkt_done_q  <= pkt_done_d;
            cs_abort_q  <= cs_abort_d;
        end
    end

    assign spi_miso    = miso_q;
    assign ready       = ready_q;
    assign pkt_done    = pkt_done_q;
    assign cs_abort    = cs_abort_q;
    assign seg_num     = cur_seg_q;
    assign frame_count = cur_frame_q;
    assign pkt_id      = pkt_word(cur_idx_q, cur_seg_q, cur_frame_q[0], cur_crc_q, WRD_W'(0), 1'b0);

endmodule

// File: tb/tb_lepton_vospi_emulator.sv
// tb/tb_lepton_vospi_emulator.sv - scoreboard bench for the VoSPI emulator
// Small packet geometry keeps a full frame short; SCK runs at clk/8.
module tb_lepton_vospi_emulator;
    localparam int P_PKTS = 21;
    localparam int P_PIX  = 6;
    localparam int P_SEGS = 3;
    localparam int P_DISC = 2;
    localparam int NW     = P_PIX + 2;

    logic        clk = 1'b0;
    logic        rst, enable, spi_clk, spi_cs;
    logic        spi_miso, ready, pkt_done, cs_abort;
    logic [15:0] pkt_id;
    logic [2:0]  seg_num;
    logic [3:0]  frame_count;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pkt_w [NW];
    logic [15:0] rx_pkt [NW];
    int          b_idx, b_seg, b_frame;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    logic [15:0] rx_sh;
    int          rx_nb = 0;
    int          rx_wi = 0;

    always #5 clk = ~clk;

    lepton_vospi_emulator #(
        .PKTS_PER_SEG(P_PKTS), .PIX_PER_PKT(P_PIX), .SEGS_PER_FRAME(P_SEGS),
        .DISCARD_PKTS(P_DISC), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .spi_clk(spi_clk), .spi_cs(spi_cs),
        .spi_miso(spi_miso), .ready(ready), .pkt_done(pkt_done), .cs_abort(cs_abort),
        .pkt_id(pkt_id), .seg_num(seg_num), .frame_count(frame_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pkt_done) done_cnt++;
        if (cs_abort) abort_cnt++;
    end

    // Master-side receiver: samples on SCK rise, pops one expectation per word.
    always @(posedge spi_clk or posedge spi_cs) begin
        if (spi_cs) begin
            rx_nb = 0;
            rx_wi = 0;
        end else begin
            rx_sh = {rx_sh[14:0], spi_miso};
            rx_nb++;
            if (rx_nb == 16) begin
                rx_nb = 0;
                rx_pkt[rx_wi] = rx_sh;
                rx_wi = (rx_wi == NW - 1) ? 0 : rx_wi + 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_extra: got %h expected none", rx_sh);
                end else begin
                    check("rx_word", rx_sh, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        c = c_in;
        for (int b = 15; b >= 0; b--) begin
            logic fb;
            fb = c[15] ^ d[b];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic void build_pkt();
        int n;
        logic [15:0] crc;
        n = b_idx - P_DISC;
        for (int k = 0; k < NW; k++) pkt_w[k] = 16'h0000;
        if (b_idx < P_DISC) begin
            pkt_w[0] = 16'h0FFF;
            pkt_w[1] = 16'hFFFF;
        end else begin
            pkt_w[0] = 16'(n);
            for (int i = 0; i < P_PIX; i++)
                pkt_w[i + 2] = 16'((b_frame % 2) * 32768 + (b_seg - 1) * 8192 + n * 128 + i);
            crc = 16'h0000;
            for (int k = 0; k < NW; k++) crc = crc_upd(crc, pkt_w[k]);
            pkt_w[1] = crc;
            if (n == 20) pkt_w[0] = pkt_w[0] + 16'(b_seg * 4096);
        end
    endfunction

    function automatic void advance();
        b_idx++;
        if (b_idx == P_DISC + P_PKTS) begin
            b_idx = 0;
            if (b_seg == P_SEGS) begin
                b_seg   = 1;
                b_frame = (b_frame + 1) % 16;
            end else begin
                b_seg++;
            end
        end
    endfunction

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
        end
    endtask

    task automatic cs_low();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cs", ready, 1'b1);
        spi_cs = 1'b0;
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_pkt();
        int d0;
        build_pkt();
        for (int k = 0; k < NW; k++) exp_q.push_back(pkt_w[k]);
        d0 = done_cnt;
        shift_bits(NW * 16);
        repeat (4) @(negedge clk);
        check("pkt_done_pulse", done_cnt - d0, 1);
        advance();
        build_pkt();
        check("seg_num", seg_num, b_seg);
        check("frame_count", frame_count, b_frame);
        check("pkt_id", pkt_id, pkt_w[0]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0, g;
        rst = 1'b1; enable = 1'b1; spi_clk = 1'b1; spi_cs = 1'b1;
        b_idx = 0; b_seg = 1; b_frame = 0;
        repeat (3) @(negedge clk);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_cs_abort", cs_abort, 1'b0);
        check("rst_seg_num", seg_num, 3'd1);
        check("rst_frame_count", frame_count, 4'd0);
        check("rst_pkt_id", pkt_id, 16'h0FFF);
        rst = 1'b0;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency_ok", n <= P_PIX + 4, 1'b1);

        a0 = abort_cnt;
        cs_low();
        send_pkt();
        send_pkt();
        cs_high();
        check("boundary_no_abort", abort_cnt - a0, 0);
        check("discard_id", rx_pkt[0], 16'h0FFF);
        check("discard_crc", rx_pkt[1], 16'hFFFF);
        check("discard_pix", rx_pkt[NW - 1], 16'h0000);

        cs_low();
        send_pkt();
        check("video0_id", rx_pkt[0], 16'h0000);
        check("video0_pix5", rx_pkt[7], 16'h0005);

        g = 0;
        while (!(b_seg == 3 && b_idx == P_DISC + 20) && g < 200) begin
            send_pkt();
            g++;
        end
        send_pkt();
        check("seg3_pkt20_id", rx_pkt[0], 16'h3014);
        check("seg3_pkt20_pix0", rx_pkt[2], 16'h4A00);
        check("wrap_seg_num", seg_num, 3'd1);
        check("wrap_frame_count", frame_count, 4'd1);

        send_pkt();
        send_pkt();
        build_pkt();
        exp_q.push_back(pkt_w[0]);
        exp_q.push_back(pkt_w[1]);
        a0 = abort_cnt;
        shift_bits(37);
        cs_high();
        check("cs_abort_pulse", abort_cnt - a0, 1);
        check("abort_miso_low", spi_miso, 1'b0);
        check("abort_pkt_id_hold", pkt_id, 16'h0000);
        cs_low();
        send_pkt();
        check("resend_id", rx_pkt[0], 16'h0000);
        check("frame1_pix0", rx_pkt[2], 16'h8000);

        build_pkt();
        for (int k = 0; k < 5; k++) exp_q.push_back(pkt_w[k]);
        shift_bits(5 * 16 + 7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_miso", spi_miso, 1'b0);
        check("midrst_ready", ready, 1'b0);
        check("midrst_pkt_id", pkt_id, 16'h0FFF);
        check("midrst_seg_num", seg_num, 3'd1);
        check("midrst_frame_count", frame_count, 4'd0);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        b_idx = 0; b_seg = 1; b_frame = 0;
        cs_low();
        send_pkt();
        cs_high();
        check("post_rst_id", rx_pkt[0], 16'h0FFF);
        check("post_rst_crc", rx_pkt[1], 16'hFFFF);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
